// File: rtl/spi_cpu_port_if.sv
// spi_cpu_port_if: Z80 I/O bus as seen by the SPI CPU port.
//   master modport: CPU / bus-mux side (drives address, strobes, write data)
//   slave modport : spi_cpu_port side (returns read data, output enable, WAIT)
// Signals:
//   cpu_addr[7:0]  low address byte A[7:0]
//   cpu_iorq_n     IORQ, active low
//   cpu_m1_n       M1, active low (IORQ with M1 low is an interrupt ack)
//   cpu_rd_n       RD, active low
//   cpu_wr_n       WR, active low
//   cpu_din[7:0]   CPU output data bus
//   cpu_dout[7:0]  data returned to the CPU
//   cpu_oe         high when cpu_dout must drive the CPU input bus
//   cpu_wait_n     WAIT, active low
interface spi_cpu_port_if;
  logic [7:0] cpu_addr;
  logic       cpu_iorq_n;
  logic       cpu_m1_n;
  logic       cpu_rd_n;
  logic       cpu_wr_n;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_oe;
  logic       cpu_wait_n;

  modport master (
    output cpu_addr, cpu_iorq_n, cpu_m1_n, cpu_rd_n, cpu_wr_n, cpu_din,
    input  cpu_dout, cpu_oe, cpu_wait_n
  );

  modport slave (
    input  cpu_addr, cpu_iorq_n, cpu_m1_n, cpu_rd_n, cpu_wr_n, cpu_din,
    output cpu_dout, cpu_oe, cpu_wait_n
  );
endinterface

// File: rtl/spi_cpu_port.sv
// spi_cpu_port: Z80 I/O-port front end for the SPI byte engine.
// Decodes CPU I/O cycles to a data port (starts engine transfers) and a
// control/status port (SD chip selects, busy, overrun). Tracks transfer
// duration with a down-counter so software can poll busy.
//
// Optional build macro: SPI_CPU_PORT_WAIT_EN
//   defined   : a data-port access while busy is held off with cpu_wait_n
//               until the engine is free (PEND state); overrun never set.
//   undefined : cpu_wait_n tied high; a data-port access while busy is
//               dropped and sets the overrun flag.
//
// Ports:
//   clk            system clock (7 MHz)
//   reset          synchronous, active-high
//   cpu            spi_cpu_port_if.slave, Z80 I/O bus
//   spi_tx_strobe  to engine: start write transfer
//   spi_rx_strobe  to engine: start read transfer
//   spi_din[7:0]   byte to transmit
//   spi_dout[7:0]  engine's last received byte (valid while rx strobe high)
//   sd_cs_n[1:0]   SD chip selects, active low
//   busy           transfer in progress
//
// State | meaning
// IDLE   | waiting for a data-port access
// STROBE | first strobe cycle; read data captured here
// HOLD   | strobe held until the CPU access ends
// PEND   | (WAIT build only) CPU held by WAIT until engine free
module spi_cpu_port #(
  parameter logic [7:0] DATA_PORT   = 8'hEB,
  parameter logic [7:0] CTRL_PORT   = 8'hE7,
  parameter int         XFER_CYCLES = 18
) (
  input  logic           clk,
  input  logic           reset,
  spi_cpu_port_if.slave  cpu,
  output logic           spi_tx_strobe,
  output logic           spi_rx_strobe,
  output logic [7:0]     spi_din,
  input  logic [7:0]     spi_dout,
  output logic [1:0]     sd_cs_n,
  output logic           busy
);

  if (XFER_CYCLES < 17 || XFER_CYCLES > 31) begin : g_bad_xfer
    $error("spi_cpu_port: XFER_CYCLES must be within 17..31");
  end

  localparam logic [4:0] XFER_LOAD = 5'(XFER_CYCLES);

`ifdef SPI_CPU_PORT_WAIT_EN
  typedef enum logic [1:0] {IDLE, STROBE, HOLD, PEND} state_t;
`else
  typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;
`endif

  state_t     state, state_nxt;
  logic       acc, acc_q, start;
  logic       dsel, csel, drd, dwr, crd, cwr;
  logic       data_start, ctrl_start;
  logic [4:0] cnt, cnt_nxt;
  logic       free;
  logic       do_start;
  logic       rd_q, rd_nxt;
  logic [7:0] spi_din_nxt;
  logic [7:0] cpu_dout_q, cpu_dout_nxt;
  logic [1:0] cs_nxt;
  logic       overrun, overrun_nxt;
  logic       ovr_set, ovr_clr;

  // Bus decode. IORQ together with M1 is an interrupt acknowledge.
  assign acc  = !cpu.cpu_iorq_n && cpu.cpu_m1_n && (!cpu.cpu_rd_n || !cpu.cpu_wr_n);
  assign dsel = acc && (cpu.cpu_addr == DATA_PORT);
  assign csel = acc && (cpu.cpu_addr == CTRL_PORT);
  assign drd  = dsel && !cpu.cpu_rd_n;
  assign dwr  = dsel && !cpu.cpu_wr_n;
  assign crd  = csel && !cpu.cpu_rd_n;
  assign cwr  = csel && !cpu.cpu_wr_n;

  assign start      = acc && !acc_q;
  assign data_start = start && dsel;
  assign ctrl_start = start && csel;

  assign cpu.cpu_oe   = drd || crd;
  assign cpu.cpu_dout = cpu_dout_q;

  assign busy = (cnt != 5'd0);
  // A counter of 1 reaches zero at this edge, so a new transfer may start.
  assign free = (cnt <= 5'd1);

  assign spi_tx_strobe = ((state == STROBE) || (state == HOLD)) && !rd_q;
  assign spi_rx_strobe = ((state == STROBE) || (state == HOLD)) &&  rd_q;

`ifdef SPI_CPU_PORT_WAIT_EN
  assign cpu.cpu_wait_n = (state != PEND);
`else
  assign cpu.cpu_wait_n = 1'b1;
`endif

  // Edge detector is left out of reset so an access already in flight when
  // reset is released is not taken as a new one.
  always_ff @(posedge clk) begin
    acc_q <= acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      rd_q       <= 1'b0;
      spi_din    <= 8'hFF;
      cpu_dout_q <= 8'hFF;
      sd_cs_n    <= 2'b11;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rd_q       <= rd_nxt;
      spi_din    <= spi_din_nxt;
      cpu_dout_q <= cpu_dout_nxt;
      sd_cs_n    <= cs_nxt;
      overrun    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = busy ? (cnt - 5'd1) : cnt;
    rd_nxt       = rd_q;
    spi_din_nxt  = spi_din;
    cpu_dout_nxt = cpu_dout_q;
    cs_nxt       = sd_cs_n;
    ovr_set      = 1'b0;
    ovr_clr      = 1'b0;
    do_start     = 1'b0;

    case (state)
      IDLE: begin
        if (data_start) begin
          if (free) begin
            do_start = 1'b1;
          end else begin
`ifdef SPI_CPU_PORT_WAIT_EN
            state_nxt = PEND;
`else
            ovr_set = 1'b1;
`endif
          end
        end
      end
      STROBE: begin
        // Engine still presents the previous byte: pipelined read.
        if (rd_q) cpu_dout_nxt = spi_dout;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!acc) state_nxt = IDLE;
      end
`ifdef SPI_CPU_PORT_WAIT_EN
      PEND: begin
        if (!acc)      state_nxt = IDLE;
        else if (free) do_start  = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (do_start) begin
      state_nxt = STROBE;
      cnt_nxt   = XFER_LOAD;
      rd_nxt    = drd;
      if (dwr) spi_din_nxt = cpu.cpu_din;
    end

    if (ctrl_start && cwr) cs_nxt = cpu.cpu_din[1:0];
    if (ctrl_start && crd) begin
      cpu_dout_nxt = {busy, overrun, 4'b0000, sd_cs_n};
      ovr_clr      = 1'b1;
    end

    // A coincident set wins over the status-read clear.
    overrun_nxt = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : overrun);
  end

endmodule
